// File: rtl/cache_axi_bridge.sv
// Bridge from the L1 cache refill/write-back interface to AXI4.
// Independent read and write FSMs; reads wait for same-line write-backs to finish.
module cache_axi_bridge #(
    parameter logic [3:0] R_ID = 4'd0,
    parameter logic [3:0] W_ID = 4'd1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic         awvalid,
    input  logic         awready,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

    r_state_t     r_state, r_next;
    w_state_t     w_state, w_next;
    logic [31:0]  ra_q;
    logic [2:0]   rt_q;
    logic [31:0]  wa_q;
    logic [2:0]   wt_q;
    logic [3:0]   ws_q;
    logic [127:0] wd_q;
    logic [1:0]   cnt;
    logic         raw_block;
    logic         rd_fire;
    logic         wr_fire;
    logic         w_fire;
    logic         w_line;
    logic         unused;

    assign unused = ^{rid, rresp, bid, bresp};

    assign wr_rdy  = (w_state == W_IDLE);
    assign wr_fire = wr_req & wr_rdy;

    // A same-cycle write to this line is accepted first, so it blocks too
    assign raw_block = ((w_state != W_IDLE) && (wa_q[31:4] == rd_addr[31:4]))
                     || (wr_fire && (wr_addr[31:4] == rd_addr[31:4]));
    assign rd_rdy    = (r_state == R_IDLE) & ~raw_block;
    assign rd_fire   = rd_req & rd_rdy;

    assign arid    = R_ID;
    assign araddr  = ra_q;
    assign arlen   = (rt_q == 3'b100) ? 8'd3 : 8'd0;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign awid    = W_ID;
    assign awaddr  = wa_q;
    assign awlen   = (wt_q == 3'b100) ? 8'd3 : 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;

    assign w_line = (wt_q == 3'b100);
    assign w_fire = wvalid & wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            ra_q    <= '0;
            rt_q    <= '0;
        end else begin
            r_state <= r_next;
            if (rd_fire) begin
                ra_q <= rd_addr;
                rt_q <= rd_type;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (rd_fire) r_next = R_AR;
            R_AR:   if (arready) r_next = R_DATA;
            R_DATA: if (rvalid && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arvalid   = (r_state == R_AR);
        rready    = (r_state == R_DATA);
        ret_valid = (r_state == R_DATA) & rvalid;
        ret_last  = rlast;
        ret_data  = rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            wa_q    <= '0;
            wt_q    <= '0;
            ws_q    <= '0;
            wd_q    <= '0;
            cnt     <= '0;
        end else begin
            w_state <= w_next;
            if (wr_fire) begin
                wa_q <= wr_addr;
                wt_q <= wr_type;
                ws_q <= wr_wstrb;
                wd_q <= wr_data;
                cnt  <= '0;
            end else if (w_fire) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE: if (wr_fire) w_next = W_AW;
            W_AW:   if (awready) w_next = W_DATA;
            W_DATA: if (w_fire && wlast) w_next = W_RESP;
            W_RESP: if (bvalid) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awvalid = (w_state == W_AW);
        wvalid  = (w_state == W_DATA);
        bready  = (w_state == W_RESP);
        wdata   = w_line ? wd_q[{cnt, 5'b0} +: 32] : wd_q[31:0];
        wstrb   = w_line ? 4'hf : ws_q;
        wlast   = w_line ? (cnt == 2'd3) : 1'b1;
    end

endmodule
